// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 8/4 signed divider.
package div_pkg;

  localparam int DIV_DW   = 8;
  localparam int DIV_VW   = 4;
  localparam int DIV_ITER = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // -128 would overflow an 8-bit negate, so widen before negating
  function automatic logic [8:0] mag9(input logic [7:0] a);
    logic [8:0] ext;
    ext = {a[7], a};
    return a[7] ? (9'd0 - ext) : ext;
  endfunction

  function automatic logic [4:0] mag5(input logic [3:0] b);
    logic [4:0] ext;
    ext = {b[3], b};
    return b[3] ? (5'd0 - ext) : ext;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on a 5-bit partial remainder.
module div_step
  import div_pkg::*;
(
  input  logic [4:0] prem,
  input  logic [3:0] dmag,
  output logic [4:0] rem_nxt,
  output logic       q_bit
);

  logic [4:0] dext;
  logic [4:0] diff;

  assign dext    = {1'b0, dmag};
  assign diff    = prem - dext;
  assign q_bit   = (prem >= dext);
  assign rem_nxt = q_bit ? diff : prem;

endmodule

// File: rtl/div8s4_seq.sv
// Sequential signed 8/4 truncating divider, one quotient bit per cycle.
module div8s4_seq
  import div_pkg::*;
#(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  div_state_t state;

  logic [7:0] a_sh;
  logic [3:0] b_mag;
  logic       neg_a;
  logic       neg_b;
  logic [4:0] prem;
  logic [3:0] cnt;
  logic [7:0] q_acc;
  logic       byp_dbz;
  logic       byp_ovf;

  logic [8:0] a_abs;
  logic [4:0] b_abs;
  logic [4:0] prem_sh;
  logic [4:0] rem_nxt;
  logic       q_bit;
  logic [7:0] q_fin;
  logic [3:0] r_mag;

  assign a_abs   = mag9(dividend);
  assign b_abs   = mag5(divisor);
  assign prem_sh = {prem[3:0], a_sh[7]};
  assign q_fin   = {q_acc[6:0], q_bit};
  assign r_mag   = rem_nxt[3:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  div_step u_step (
    .prem    (prem_sh),
    .dmag    (b_mag),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_mag     <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      prem      <= '0;
      cnt       <= '0;
      q_acc     <= '0;
      byp_dbz   <= 1'b0;
      byp_ovf   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a_abs[7:0];
            b_mag   <= b_abs[3:0];
            neg_a   <= dividend[7];
            neg_b   <= divisor[3];
            prem    <= '0;
            cnt     <= '0;
            q_acc   <= '0;
            byp_dbz <= (divisor == 4'h0);
            byp_ovf <= (dividend == 8'h80) &&
                       (divisor == 4'hF);
            state   <= CALC;
          end
        end
        CALC: begin
          if (byp_dbz) begin
            quotient  <= 8'h00;
            remainder <= 4'h0;
            dbz       <= 1'b1;
            ovf       <= 1'b0;
            state     <= DONE;
          end else if (byp_ovf) begin
            quotient  <= 8'h80;
            remainder <= 4'h0;
            dbz       <= 1'b0;
            ovf       <= 1'b1;
            state     <= DONE;
          end else begin
            prem  <= rem_nxt;
            a_sh  <= {a_sh[6:0], 1'b0};
            q_acc <= q_fin;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'(DIV_ITER - 1)) begin
              quotient  <= (neg_a ^ neg_b) ? -q_fin : q_fin;
              remainder <= neg_a ? -r_mag : r_mag;
              dbz       <= 1'b0;
              ovf       <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div8s4_seq.sv
// Directed self-checking bench for div8s4_seq.
module tb_div8s4_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;
  logic       ovf;

  int total;
  int passed;

  div8s4_seq #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = 4'h3;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name,
                        input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic edbz, input logic eovf,
                        input int elat);
    int lat;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL %s ready_before got=%b exp=1", name, in_ready);
    else passed++;
    start_op(a, b);
    wait_valid(lat);
    total++;
    if (lat !== elat)
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat);
    else passed++;
    total++;
    if (quotient !== eq || remainder !== er || dbz !== edbz || ovf !== eovf)
      $display("FAIL %s result got q=%h r=%h dbz=%b ovf=%b exp q=%h r=%h dbz=%b ovf=%b",
               name, quotient, remainder, dbz, ovf, eq, er, edbz, eovf);
    else passed++;
    consume();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s after_consume got ov=%b rdy=%b exp ov=0 rdy=1",
               name, out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = 8'h00;
    divisor = 4'h0;
    #23;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_hs got rdy=%b ov=%b exp rdy=1 ov=0", in_ready, out_valid);
    else passed++;
    total++;
    if (quotient !== 8'h00 || remainder !== 4'h0 || dbz !== 1'b0 || ovf !== 1'b0)
      $display("FAIL reset_out got q=%h r=%h dbz=%b ovf=%b exp 00 0 0 0",
               quotient, remainder, dbz, ovf);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op("pos_pos", 8'd100, 4'd7, 8'h0E, 4'h2, 1'b0, 1'b0, 8);
  endtask

  task automatic test_signs();
    run_op("neg_pos", 8'h9C, 4'd7, 8'hF2, 4'hE, 1'b0, 1'b0, 8);
    run_op("pos_neg", 8'd100, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0, 8);
    run_op("neg_neg", 8'h9C, 4'h9, 8'h0E, 4'hE, 1'b0, 1'b0, 8);
    run_op("127_m8", 8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0, 1'b0, 8);
  endtask

  task automatic test_bypass();
    run_op("dbz", 8'd5, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 1);
    run_op("ovf", 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 1);
  endtask

  task automatic test_min_dividend();
    run_op("m128_m8", 8'h80, 4'h8, 8'h10, 4'h0, 1'b0, 1'b0, 8);
    run_op("m128_7", 8'h80, 4'd7, 8'hEE, 4'hE, 1'b0, 1'b0, 8);
    run_op("m128_1", 8'h80, 4'd1, 8'h80, 4'h0, 1'b0, 1'b0, 8);
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    start_op(8'd100, 4'd7);
    wait_valid(lat);
    total++;
    if (lat !== 8)
      $display("FAIL stall_latency got=%0d exp=8", lat);
    else passed++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          quotient !== 8'h0E || remainder !== 4'h2 ||
          dbz !== 1'b0 || ovf !== 1'b0)
        bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL stall_hold got bad_cycles=%0d exp=0 (q=%h r=%h ov=%b rdy=%b)",
               bad, quotient, remainder, out_valid, in_ready);
    else passed++;
    consume();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_consume got ov=%b rdy=%b exp ov=0 rdy=1",
               out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen;
    start_op(8'd100, 4'd7);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'h00)
      $display("FAIL midreset_async got rdy=%b ov=%b q=%h exp rdy=1 ov=0 q=00",
               in_ready, out_valid, quotient);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0)
      $display("FAIL midreset_noresult got valid_cycles=%0d exp=0", seen);
    else passed++;
    run_op("after_reset", 8'd100, 4'd7, 8'h0E, 4'h2, 1'b0, 1'b0, 8);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 8'd9, 4'd3, 8'h03, 4'h0, 1'b0, 1'b0, 8);
    run_op("b2b_b", 8'hF9, 4'd2, 8'hFD, 4'hF, 1'b0, 1'b0, 8);
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_basic();
    test_signs();
    test_bypass();
    test_min_dividend();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
